// File: rtl/dma_rd_arb_pkg.sv
// Shared state encoding, AXI burst constant and sizing helpers for the DMA read arbiter.
package dma_rd_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [2:0] arsize_enc(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/dma_rd_arbiter_if.sv
// Requester-side AR/R channels plus the shared AXI read master port.
// master = arbiter view, slave = requesters plus AXI slave view.
interface dma_rd_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr;
    logic [NUM_REQ-1:0]            s_arvalid;
    logic [NUM_REQ-1:0]            s_arready;
    logic [DATA_WIDTH-1:0]         s_rdata;
    logic                          s_rlast;
    logic [NUM_REQ-1:0]            s_rvalid;
    logic [NUM_REQ-1:0]            s_rready;

    logic [ADDR_WIDTH-1:0]         m_araddr;
    logic [7:0]                    m_arlen;
    logic [2:0]                    m_arsize;
    logic [1:0]                    m_arburst;
    logic                          m_arvalid;
    logic                          m_arready;
    logic [DATA_WIDTH-1:0]         m_rdata;
    logic                          m_rlast;
    logic                          m_rvalid;
    logic                          m_rready;

    modport master (
        input  s_araddr, s_arvalid, s_rready,
               m_arready, m_rdata, m_rlast, m_rvalid,
        output s_arready, s_rdata, s_rlast, s_rvalid,
               m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready
    );

    modport slave (
        output s_araddr, s_arvalid, s_rready,
               m_arready, m_rdata, m_rlast, m_rvalid,
        input  s_arready, s_rdata, s_rlast, s_rvalid,
               m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready
    );

endinterface

// File: rtl/dma_rd_order_fifo.sv
// Grant-order FIFO, first-word fall-through: dout shows the head whenever not empty.
// Push while full is dropped unless a pop frees the slot in the same cycle.
module dma_rd_order_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dma_rd_arbiter.sv
// Shares one AXI read port among NUM_REQ DMA engines; AR grant takes 2 cycles, R steering is combinational.
// Round-robin grant unless DMA_RD_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module dma_rd_arbiter
    import dma_rd_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int BURST_LEN       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    dma_rd_arbiter_if.master                 bus,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                             err_rlast
);
    localparam int IW   = idx_width(NUM_REQ);
    localparam int CNTW = idx_width(BURST_LEN);

    localparam logic [0:0] ST_IDLE  = ARB_IDLE;
    localparam logic [0:0] ST_ISSUE = ARB_ISSUE;

    logic [0:0]            state;
    logic [IW-1:0]         grant;
    logic [IW-1:0]         winner;
    logic [IW-1:0]         head;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  arvalid_q;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  last_beat;
    logic                  head_rdy;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CNTW-1:0]       beat_cnt;

`ifdef DMA_RD_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.s_arvalid[i]) winner = IW'(i);
        end
    end
`else
    logic [IW-1:0] last_grant;

    // Scan farthest-first so the requester right after last_grant is assigned last and wins.
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == (int'(last_grant) + k) % NUM_REQ && bus.s_arvalid[i]) winner = IW'(i);
            end
        end
    end
`endif

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IW'(i)) win_addr = bus.s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    assign ar_hs = (state == ST_ISSUE) & arvalid_q & bus.m_arready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            grant     <= '0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
`ifndef DMA_RD_ARB_FIXED_PRIO_EN
            last_grant <= IW'(NUM_REQ - 1);
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if ((|bus.s_arvalid) && !fifo_full) begin
                        grant     <= winner;
                        araddr_q  <= win_addr;
                        arvalid_q <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        state     <= ST_IDLE;
`ifndef DMA_RD_ARB_FIXED_PRIO_EN
                        last_grant <= grant;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.s_arready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ar_hs && grant == IW'(i)) bus.s_arready[i] = 1'b1;
        end
    end

    assign bus.m_araddr  = araddr_q;
    assign bus.m_arvalid = arvalid_q;
    assign bus.m_arlen   = 8'(BURST_LEN - 1);
    assign bus.m_arsize  = arsize_enc(DATA_WIDTH);
    assign bus.m_arburst = AXI_BURST_INCR;

    // R beats always belong to the FIFO head; an empty FIFO blocks the channel.
    always_comb begin
        bus.s_rvalid = '0;
        head_rdy     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (head == IW'(i)) begin
                bus.s_rvalid[i] = bus.m_rvalid & ~fifo_empty;
                head_rdy        = bus.s_rready[i];
            end
        end
    end

    assign bus.m_rready = ~fifo_empty & head_rdy;
    assign bus.s_rdata  = bus.m_rdata;
    assign bus.s_rlast  = bus.m_rlast;
    assign r_hs         = bus.m_rvalid & bus.m_rready;
    assign last_beat    = (beat_cnt == CNTW'(BURST_LEN - 1));

    // Burst end comes from the beat count; m_rlast is only cross-checked.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            beat_cnt  <= '0;
            err_rlast <= 1'b0;
        end else if (r_hs) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + CNTW'(1);
            if (bus.m_rlast != last_beat) err_rlast <= 1'b1;
        end
    end

    dma_rd_order_fifo #(
        .WIDTH (IW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (ar_hs),
        .pop   (r_hs & last_beat),
        .din   (grant),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (outstanding)
    );

endmodule

// File: tb/tb_dma_rd_arbiter.sv
// Directed bench for dma_rd_arbiter: AR grant table plus hand-written burst, error and reset sequences.
module tb_dma_rd_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BL = 16;
    localparam int MO = 4;

    typedef struct {
        logic [3:0]  arvalid;
        logic        arready;
        logic        exp_mvld;
        logic [3:0]  exp_sardy;
        logic [31:0] exp_addr;
        logic [2:0]  exp_out;
        int          exp_grant;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] outstanding;
    logic       err_rlast;
    int         checks = 0;
    int         errors = 0;
    logic       exp_err = 1'b0;
    int         exp_owner[$];
    int         g[4];
    vec_t       tbl[11];

    dma_rd_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dma_rd_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .BURST_LEN(BL), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .outstanding (outstanding),
        .err_rlast   (err_rlast)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] req_addr(input int i);
        return 32'h0001_0000 + 32'(i) * 32'h100;
    endfunction

    function automatic logic [63:0] beat_data(input int owner, input int beat);
        return {32'(owner) ^ 32'hA5A5_0000, 32'(beat)};
    endfunction

    // One full burst for the head owner; optional 3-cycle owner stall and an early rlast.
    task automatic run_burst(input int owner, input int stall_at, input int bad_last,
                             input logic [2:0] exp_out);
        int   beat;
        int   stall;
        logic stalled;
        logic rl;
        beat  = 0;
        stall = 0;
        while (beat < BL) begin
            stalled = (beat == stall_at) && (stall < 3);
            rl      = (beat == BL - 1) || (beat == bad_last);
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = beat_data(owner, beat);
            bus.m_rlast  = rl;
            bus.s_rready = stalled ? ~(4'(1) << owner) : 4'hF;
            #1;
            chk($sformatf("r_svalid_b%0d", beat), 64'(bus.s_rvalid), 64'(4'(1) << owner));
            chk($sformatf("r_mready_b%0d", beat), 64'(bus.m_rready), 64'(!stalled));
            chk($sformatf("r_data_b%0d", beat), bus.s_rdata, beat_data(owner, beat));
            chk($sformatf("r_rlast_b%0d", beat), 64'(bus.s_rlast), 64'(rl));
            chk($sformatf("r_out_b%0d", beat), 64'(outstanding), 64'(exp_out));
            chk($sformatf("r_err_b%0d", beat), 64'(err_rlast), 64'(exp_err));
            chk($sformatf("r_mvld_b%0d", beat), 64'(bus.m_arvalid), 64'(0));
            if (stalled) begin
                stall++;
            end else begin
                if (rl != (beat == BL - 1)) exp_err = 1'b1;
                beat++;
            end
            step();
        end
        bus.m_rvalid = 1'b0;
        bus.m_rlast  = 1'b0;
        bus.s_rready = 4'h0;
    endtask

    task automatic issue(input int req, input logic [31:0] addr);
        bus.s_araddr = '0;
        bus.s_araddr[req*32 +: 32] = addr;
        bus.s_arvalid = 4'(1) << req;
        bus.m_arready = 1'b1;
        #1;
        chk("iss_idle_mvld", 64'(bus.m_arvalid), 64'(0));
        step();
        #1;
        chk("iss_sardy", 64'(bus.s_arready), 64'(4'(1) << req));
        chk("iss_addr", 64'(bus.m_araddr), 64'(addr));
        step();
        bus.s_arvalid = 4'h0;
    endtask

    initial begin
`ifdef DMA_RD_ARB_FIXED_PRIO_EN
        g = '{0, 0, 0, 0};
`else
        g = '{0, 1, 2, 3};
`endif
        tbl[0]  = '{4'hF, 1'b1, 1'b0, 4'h0, 32'h0, 3'd0, -1};
        tbl[1]  = '{4'hF, 1'b0, 1'b1, 4'h0, req_addr(g[0]), 3'd0, -1};
        tbl[2]  = '{4'hF, 1'b1, 1'b1, 4'(1) << g[0], req_addr(g[0]), 3'd0, g[0]};
        tbl[3]  = '{4'hF, 1'b1, 1'b0, 4'h0, 32'h0, 3'd1, -1};
        tbl[4]  = '{4'hF, 1'b1, 1'b1, 4'(1) << g[1], req_addr(g[1]), 3'd1, g[1]};
        tbl[5]  = '{4'hF, 1'b1, 1'b0, 4'h0, 32'h0, 3'd2, -1};
        tbl[6]  = '{4'hF, 1'b1, 1'b1, 4'(1) << g[2], req_addr(g[2]), 3'd2, g[2]};
        tbl[7]  = '{4'hF, 1'b1, 1'b0, 4'h0, 32'h0, 3'd3, -1};
        tbl[8]  = '{4'hF, 1'b1, 1'b1, 4'(1) << g[3], req_addr(g[3]), 3'd3, g[3]};
        tbl[9]  = '{4'hF, 1'b1, 1'b0, 4'h0, 32'h0, 3'd4, -1};
        tbl[10] = '{4'hF, 1'b1, 1'b0, 4'h0, 32'h0, 3'd4, -1};

        bus.s_araddr  = '0;
        bus.s_arvalid = '0;
        bus.s_rready  = '0;
        bus.m_arready = 1'b0;
        bus.m_rdata   = '0;
        bus.m_rlast   = 1'b0;
        bus.m_rvalid  = 1'b0;
        rstn = 1'b0;
        repeat (2) step();

        chk("rst_mvld", 64'(bus.m_arvalid), 64'(0));
        chk("rst_sardy", 64'(bus.s_arready), 64'(0));
        chk("rst_mrdy", 64'(bus.m_rready), 64'(0));
        chk("rst_addr", 64'(bus.m_araddr), 64'(0));
        chk("rst_out", 64'(outstanding), 64'(0));
        chk("rst_err", 64'(err_rlast), 64'(0));
        chk("rst_arlen", 64'(bus.m_arlen), 64'(15));
        chk("rst_arsize", 64'(bus.m_arsize), 64'(3));
        chk("rst_arburst", 64'(bus.m_arburst), 64'(1));
        rstn = 1'b1;

        for (int i = 0; i < NR; i++) bus.s_araddr[i*32 +: 32] = req_addr(i);
        for (int r = 0; r < 11; r++) begin
            bus.s_arvalid = tbl[r].arvalid;
            bus.m_arready = tbl[r].arready;
            #1;
            chk($sformatf("ar%0d_mvld", r), 64'(bus.m_arvalid), 64'(tbl[r].exp_mvld));
            chk($sformatf("ar%0d_sardy", r), 64'(bus.s_arready), 64'(tbl[r].exp_sardy));
            chk($sformatf("ar%0d_out", r), 64'(outstanding), 64'(tbl[r].exp_out));
            if (tbl[r].exp_mvld) chk($sformatf("ar%0d_addr", r), 64'(bus.m_araddr), 64'(tbl[r].exp_addr));
            if (tbl[r].exp_grant >= 0) exp_owner.push_back(tbl[r].exp_grant);
            step();
        end

        // Fifth request held off until the first burst drains.
        run_burst(exp_owner.pop_front(), -1, -1, 3'd4);
        #1;
        chk("full5_mvld_gap", 64'(bus.m_arvalid), 64'(0));
        chk("full5_out", 64'(outstanding), 64'(3));
        step();
        #1;
        chk("full5_mvld", 64'(bus.m_arvalid), 64'(1));
        chk("full5_sardy", 64'(bus.s_arready), 64'(1));
        chk("full5_addr", 64'(bus.m_araddr), 64'(req_addr(0)));
        exp_owner.push_back(0);
        step();
        bus.s_arvalid = 4'h0;
        #1;
        chk("full5_out_after", 64'(outstanding), 64'(4));
        for (int b = 4; b >= 1; b--) run_burst(exp_owner.pop_front(), -1, -1, 3'(b));
        #1;
        chk("drain_out", 64'(outstanding), 64'(0));

        bus.m_rvalid = 1'b1;
        bus.s_rready = 4'hF;
        #1;
        chk("empty_mrdy", 64'(bus.m_rready), 64'(0));
        chk("empty_svalid", 64'(bus.s_rvalid), 64'(0));
        bus.m_rvalid = 1'b0;
        step();

        bus.s_araddr = '0;
        bus.s_araddr[2*32 +: 32] = 32'h0000_1000;
        bus.s_arvalid = 4'b0100;
        bus.m_arready = 1'b0;
        #1;
        chk("one_mvld_idle", 64'(bus.m_arvalid), 64'(0));
        step();
        #1;
        chk("one_mvld", 64'(bus.m_arvalid), 64'(1));
        chk("one_addr", 64'(bus.m_araddr), 64'h1000);
        chk("one_arlen", 64'(bus.m_arlen), 64'(15));
        chk("one_arsize", 64'(bus.m_arsize), 64'(3));
        chk("one_arburst", 64'(bus.m_arburst), 64'(1));
        chk("one_sardy_wait", 64'(bus.s_arready), 64'(0));
        step();
        bus.m_arready = 1'b1;
        #1;
        chk("one_sardy", 64'(bus.s_arready), 64'(4'b0100));
        step();
        bus.s_arvalid = 4'h0;
        #1;
        chk("one_out", 64'(outstanding), 64'(1));
        chk("one_sardy_drop", 64'(bus.s_arready), 64'(0));
        run_burst(2, 5, -1, 3'd1);
        #1;
        chk("one_out_done", 64'(outstanding), 64'(0));
        chk("one_err", 64'(err_rlast), 64'(0));

        issue(1, 32'h0000_2000);
        #1;
        chk("rl_out", 64'(outstanding), 64'(1));
        run_burst(1, -1, 9, 3'd1);
        #1;
        chk("rl_err_sticky", 64'(err_rlast), 64'(1));
        chk("rl_out_done", 64'(outstanding), 64'(0));
        step();
        #1;
        chk("rl_err_held", 64'(err_rlast), 64'(1));

        issue(3, 32'h0000_3000);
        issue(0, 32'h0000_4000);
        #1;
        chk("rs_out_pre", 64'(outstanding), 64'(2));
        rstn = 1'b0;
        bus.m_rvalid = 1'b1;
        bus.s_rready = 4'hF;
        step();
        rstn = 1'b1;
        #1;
        chk("rs_mvld", 64'(bus.m_arvalid), 64'(0));
        chk("rs_sardy", 64'(bus.s_arready), 64'(0));
        chk("rs_svalid", 64'(bus.s_rvalid), 64'(0));
        chk("rs_mrdy", 64'(bus.m_rready), 64'(0));
        chk("rs_addr", 64'(bus.m_araddr), 64'(0));
        chk("rs_out", 64'(outstanding), 64'(0));
        chk("rs_err", 64'(err_rlast), 64'(0));
        chk("rs_arlen", 64'(bus.m_arlen), 64'(15));
        bus.m_rvalid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
